// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lift_pkg
// Brief   : Shared state encoding and pending-request search helpers for the
//           single-car lift controller.
// Rev     : 1.0  initial release
// ============================================================================
package lift_pkg;

  // Widest car the helpers support; callers zero-extend their pending mask.
  localparam int LIFT_MAX_FLOORS = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } lift_state_e;

  function automatic logic any_above(input logic [LIFT_MAX_FLOORS-1:0] mask,
                                     input int unsigned floor);
    logic found;
    found = 1'b0;
    for (int unsigned i = 0; i < LIFT_MAX_FLOORS; i++) begin
      if ((i > floor) && mask[i]) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic any_below(input logic [LIFT_MAX_FLOORS-1:0] mask,
                                     input int unsigned floor);
    logic found;
    found = 1'b0;
    for (int unsigned i = 0; i < LIFT_MAX_FLOORS; i++) begin
      if ((i < floor) && mask[i]) found = 1'b1;
    end
    return found;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lift_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : lift_ctrl_if
// Brief   : Button inputs and car status outputs of one lift car.
// Rev     : 1.0  initial release
// ============================================================================
interface lift_ctrl_if #(
  parameter int FLOORS = 8
);
  localparam int FLOOR_W = $clog2(FLOORS);

  logic [FLOORS-1:0]  car_btn;
  logic [FLOORS-1:0]  hall_up;
  logic [FLOORS-1:0]  hall_dn;
  logic [FLOOR_W-1:0] current_floor;
  logic               moving_up;
  logic               moving_down;
  logic               door_open;
  logic               dir_up;
  logic [FLOORS-1:0]  pend_car;
  logic [FLOORS-1:0]  pend_up;
  logic [FLOORS-1:0]  pend_dn;

  modport master (
    output car_btn, hall_up, hall_dn,
    input  current_floor, moving_up, moving_down, door_open, dir_up,
    input  pend_car, pend_up, pend_dn
  );

  modport slave (
    input  car_btn, hall_up, hall_dn,
    output current_floor, moving_up, moving_down, door_open, dir_up,
    output pend_car, pend_up, pend_dn
  );
endinterface
`default_nettype wire

// File: rtl/lift_req_reg.sv
`default_nettype none
// ============================================================================
// Module  : lift_req_reg
// Brief   : One latched pending-request vector (set by button, cleared by
//           service mask; clear wins over a same-edge set).
// Rev     : 1.0  initial release
// ============================================================================
module lift_req_reg #(
  parameter int FLOORS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] i_set,
  input  logic [FLOORS-1:0] i_clr,
  input  logic [FLOORS-1:0] i_sup,
  output logic [FLOORS-1:0] o_pend
);
  logic [FLOORS-1:0] r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend | (i_set & ~i_sup)) & ~i_clr;
  end

  assign o_pend = r_pend;
endmodule
`default_nettype wire

// File: rtl/lift_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lift_ctrl
// Brief   : Single-car collective (SCAN) lift controller with timed travel
//           and door dwell.
// Rev     : 1.0  initial release
// ============================================================================
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  lift_ctrl_if.slave  bus
);
  localparam int FLOOR_W  = $clog2(FLOORS);
  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);

  lift_state_e         r_state, w_state_nxt;
  logic [FLOOR_W-1:0]  r_floor, w_floor_nxt, w_nf;
  logic                r_dir_up, w_dir_nxt;
  logic [TRAVEL_W-1:0] r_tcnt, w_tcnt_nxt;
  logic [DOOR_W-1:0]   r_dcnt, w_dcnt_nxt;

  logic [FLOORS-1:0] w_up_btn, w_dn_btn, w_sup, w_floor_oh, w_nf_oh;
  logic [FLOORS-1:0] w_pend_car, w_pend_up, w_pend_dn, w_pend_all;
  logic [FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
  logic              w_here_press, w_above, w_below, w_going_up, w_ahead_nf, w_stop_nf;

  // Top floor has no up-call and ground floor has no down-call.
  assign w_up_btn = {1'b0, bus.hall_up[FLOORS-2:0]};
  assign w_dn_btn = {bus.hall_dn[FLOORS-1:1], 1'b0};

  assign w_floor_oh   = FLOORS'(1) << r_floor;
  assign w_nf_oh      = FLOORS'(1) << w_nf;
  assign w_sup        = ((r_state == IDLE) || (r_state == DOOR)) ? w_floor_oh : '0;
  assign w_here_press = |((bus.car_btn | w_up_btn | w_dn_btn) & w_floor_oh);

  lift_req_reg #(.FLOORS(FLOORS)) u_req_car (
    .clk(clk), .rst_n(rst_n), .i_set(bus.car_btn), .i_clr(w_clr_car), .i_sup(w_sup), .o_pend(w_pend_car)
  );
  lift_req_reg #(.FLOORS(FLOORS)) u_req_up (
    .clk(clk), .rst_n(rst_n), .i_set(w_up_btn), .i_clr(w_clr_up), .i_sup(w_sup), .o_pend(w_pend_up)
  );
  lift_req_reg #(.FLOORS(FLOORS)) u_req_dn (
    .clk(clk), .rst_n(rst_n), .i_set(w_dn_btn), .i_clr(w_clr_dn), .i_sup(w_sup), .o_pend(w_pend_dn)
  );

  assign w_pend_all = w_pend_car | w_pend_up | w_pend_dn;
  assign w_above    = any_above(LIFT_MAX_FLOORS'(w_pend_all), 32'(r_floor));
  assign w_below    = any_below(LIFT_MAX_FLOORS'(w_pend_all), 32'(r_floor));

  // Stop decision is taken against the floor being arrived at.
  assign w_going_up = (r_state == MOVE_UP);
  assign w_nf       = w_going_up ? r_floor + 1'b1 : r_floor - 1'b1;
  assign w_ahead_nf = w_going_up ? any_above(LIFT_MAX_FLOORS'(w_pend_all), 32'(w_nf))
                                 : any_below(LIFT_MAX_FLOORS'(w_pend_all), 32'(w_nf));
  assign w_stop_nf  = w_pend_car[w_nf] | (w_going_up ? w_pend_up[w_nf] : w_pend_dn[w_nf])
                    | !w_ahead_nf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_floor  <= '0;
      r_dir_up <= 1'b1;
      r_tcnt   <= '0;
      r_dcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_floor  <= w_floor_nxt;
      r_dir_up <= w_dir_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_dcnt   <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir_up;
    w_tcnt_nxt  = '0;
    w_dcnt_nxt  = '0;
    w_clr_car   = '0;
    w_clr_up    = '0;
    w_clr_dn    = '0;
    case (r_state)
      IDLE, DOOR: begin
        if (w_here_press) begin
          w_state_nxt = DOOR;
        end else if (r_state == DOOR && r_dcnt != DOOR_LAST) begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end else if (w_above && (r_dir_up || !w_below)) begin
          w_state_nxt = MOVE_UP;
          w_dir_nxt   = 1'b1;
        end else if (w_below) begin
          w_state_nxt = MOVE_DOWN;
          w_dir_nxt   = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (r_tcnt == TRAVEL_LAST) begin
          w_floor_nxt = w_nf;
          if (w_stop_nf) begin
            w_state_nxt = DOOR;
            w_clr_car   = w_nf_oh;
            if (w_going_up) w_clr_up = w_nf_oh;
            else            w_clr_dn = w_nf_oh;
            if (!w_ahead_nf) begin
              if (w_going_up) w_clr_dn = w_nf_oh;
              else            w_clr_up = w_nf_oh;
              w_dir_nxt = !w_going_up;
            end
          end
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.current_floor = r_floor;
  assign bus.moving_up     = (r_state == MOVE_UP);
  assign bus.moving_down   = (r_state == MOVE_DOWN);
  assign bus.door_open     = (r_state == DOOR);
  assign bus.dir_up        = r_dir_up;
  assign bus.pend_car      = w_pend_car;
  assign bus.pend_up       = w_pend_up;
  assign bus.pend_dn       = w_pend_dn;
endmodule
`default_nettype wire

// File: tb/tb_lift_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lift_ctrl
// Brief   : Self-checking bench for lift_ctrl (4 floors, travel 3, door 2).
// Rev     : 1.0  initial release
// ============================================================================
module tb_lift_ctrl;
  localparam logic [2:0] S_I = 3'b000;  // {moving_up, moving_down, door_open}
  localparam logic [2:0] S_U = 3'b100;
  localparam logic [2:0] S_D = 3'b010;
  localparam logic [2:0] S_O = 3'b001;

  typedef struct packed {
    logic [1:0] floor;
    logic [2:0] st;
    logic       dir;
    logic [3:0] pc;
    logic [3:0] pu;
    logic [3:0] pd;
  } out_t;

  typedef struct {
    int         n;
    logic [3:0] car;
    logic [3:0] up;
    logic [3:0] dn;
    out_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  out_t sb_q[$];
  vec_t vecs[35];
  out_t rst_exp;

  lift_ctrl_if #(.FLOORS(4)) bus ();

  lift_ctrl #(.FLOORS(4), .TRAVEL_CYCLES(3), .DOOR_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mo(input int f, input logic [2:0] st, input logic dir,
                              input logic [3:0] pc, input logic [3:0] pu, input logic [3:0] pd);
    out_t o;
    o.floor = 2'(f);
    o.st    = st;
    o.dir   = dir;
    o.pc    = pc;
    o.pu    = pu;
    o.pd    = pd;
    return o;
  endfunction

  function automatic vec_t mk(input int n, input logic [3:0] car, input logic [3:0] up,
                              input logic [3:0] dn, input out_t exp);
    vec_t v;
    v.n   = n;
    v.car = car;
    v.up  = up;
    v.dn  = dn;
    v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name);
    out_t act;
    out_t exp;
    act = {bus.current_floor, bus.moving_up, bus.moving_down, bus.door_open, bus.dir_up,
           bus.pend_car, bus.pend_up, bus.pend_dn};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got floor=%0d up/dn/door=%b dir=%b pend car/up/dn=%b/%b/%b, expected floor=%0d up/dn/door=%b dir=%b pend car/up/dn=%b/%b/%b",
                 name, act.floor, act.st, act.dir, act.pc, act.pu, act.pd,
                 exp.floor, exp.st, exp.dir, exp.pc, exp.pu, exp.pd);
      end
    end
  endtask

  // Called at a falling edge: press for one cycle, wait n rising edges, check.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    bus.car_btn = v.car;
    bus.hall_up = v.up;
    bus.hall_dn = v.dn;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    bus.car_btn = '0;
    bus.hall_up = '0;
    bus.hall_dn = '0;
    repeat (v.n - 1) @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d", idx));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_exp = mo(0, S_I, 1'b1, 4'b0000, 4'b0000, 4'b0000);

    // Same-floor press at floor 0, with a dwell restart
    vecs[0]  = mk(1, 4'b0001, 4'b0000, 4'b0000, mo(0, S_O, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[1]  = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(0, S_O, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[2]  = mk(1, 4'b0001, 4'b0000, 4'b0000, mo(0, S_O, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[3]  = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(0, S_O, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[4]  = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(0, S_I, 1, 4'b0000, 4'b0000, 4'b0000));
    // Single trip 0 -> 2
    vecs[5]  = mk(1, 4'b0100, 4'b0000, 4'b0000, mo(0, S_I, 1, 4'b0100, 4'b0000, 4'b0000));
    vecs[6]  = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(0, S_U, 1, 4'b0100, 4'b0000, 4'b0000));
    vecs[7]  = mk(3, 4'b0000, 4'b0000, 4'b0000, mo(1, S_U, 1, 4'b0100, 4'b0000, 4'b0000));
    vecs[8]  = mk(3, 4'b0000, 4'b0000, 4'b0000, mo(2, S_O, 0, 4'b0000, 4'b0000, 4'b0000));
    vecs[9]  = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(2, S_O, 0, 4'b0000, 4'b0000, 4'b0000));
    vecs[10] = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(2, S_I, 0, 4'b0000, 4'b0000, 4'b0000));
    // Tie-break at floor 2 heading down: 0 first, then 3
    vecs[11] = mk(1, 4'b1001, 4'b0000, 4'b0000, mo(2, S_I, 0, 4'b1001, 4'b0000, 4'b0000));
    vecs[12] = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(2, S_D, 0, 4'b1001, 4'b0000, 4'b0000));
    vecs[13] = mk(3, 4'b0000, 4'b0000, 4'b0000, mo(1, S_D, 0, 4'b1001, 4'b0000, 4'b0000));
    vecs[14] = mk(3, 4'b0000, 4'b0000, 4'b0000, mo(0, S_O, 1, 4'b1000, 4'b0000, 4'b0000));
    vecs[15] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(0, S_U, 1, 4'b1000, 4'b0000, 4'b0000));
    vecs[16] = mk(9, 4'b0000, 4'b0000, 4'b0000, mo(3, S_O, 0, 4'b0000, 4'b0000, 4'b0000));
    vecs[17] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(3, S_I, 0, 4'b0000, 4'b0000, 4'b0000));
    // Start of a trip that reset interrupts
    vecs[18] = mk(1, 4'b1000, 4'b0000, 4'b0000, mo(0, S_I, 1, 4'b1000, 4'b0000, 4'b0000));
    vecs[19] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(0, S_U, 1, 4'b1000, 4'b0000, 4'b0000));
    // Collective run 0 -> 3 with hall calls, back down to 2
    vecs[20] = mk(1, 4'b1000, 4'b0000, 4'b0000, mo(0, S_I, 1, 4'b1000, 4'b0000, 4'b0000));
    vecs[21] = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(0, S_U, 1, 4'b1000, 4'b0000, 4'b0000));
    vecs[22] = mk(1, 4'b0000, 4'b0010, 4'b0100, mo(0, S_U, 1, 4'b1000, 4'b0010, 4'b0100));
    vecs[23] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(1, S_O, 1, 4'b1000, 4'b0000, 4'b0100));
    vecs[24] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(1, S_U, 1, 4'b1000, 4'b0000, 4'b0100));
    vecs[25] = mk(3, 4'b0000, 4'b0000, 4'b0000, mo(2, S_U, 1, 4'b1000, 4'b0000, 4'b0100));
    vecs[26] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(2, S_U, 1, 4'b1000, 4'b0000, 4'b0100));
    vecs[27] = mk(1, 4'b1000, 4'b0000, 4'b0000, mo(3, S_O, 0, 4'b0000, 4'b0000, 4'b0100));
    vecs[28] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(3, S_D, 0, 4'b0000, 4'b0000, 4'b0100));
    vecs[29] = mk(3, 4'b0000, 4'b0000, 4'b0000, mo(2, S_O, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[30] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(2, S_I, 1, 4'b0000, 4'b0000, 4'b0000));
    // Ignored hall bits, then a same-floor hall call opening the door
    vecs[31] = mk(1, 4'b0000, 4'b1000, 4'b0001, mo(2, S_I, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[32] = mk(1, 4'b0000, 4'b0000, 4'b0000, mo(2, S_I, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[33] = mk(1, 4'b0000, 4'b0000, 4'b0100, mo(2, S_O, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[34] = mk(2, 4'b0000, 4'b0000, 4'b0000, mo(2, S_I, 1, 4'b0000, 4'b0000, 4'b0000));

    rst_n       = 1'b1;
    bus.car_btn = '0;
    bus.hall_up = '0;
    bus.hall_dn = '0;
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(rst_exp);
    check("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i <= 17; i++) run_vec(i);

    rst_n = 1'b0;
    #1;
    sb_q.push_back(rst_exp);
    check("reset_from_floor3");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 18; i <= 19; i++) run_vec(i);

    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(rst_exp);
    check("reset_mid_travel");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    sb_q.push_back(rst_exp);
    check("idle_after_reset");

    for (int i = 20; i <= 34; i++) run_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lift_ctrl.md
# lift_ctrl

Parametrised elevator car controller for one car serving `FLOORS` floors. It latches car-panel and hall (up/down) call buttons and moves the car with a collective up/down (SCAN) policy. Floor-to-floor travel and door dwell are timed with counters. It replaces the combinational next-floor logic with a registered state machine and is the single-car building block for multi-car dispatch later.

## Interface
- `FLOORS`, default 8: number of floors; must be ≥ 2.
- `TRAVEL_CYCLES`, default 16: cycles to move one floor; must be ≥ 1.
- `DOOR_CYCLES`, default 32: cycles the door stays open per stop; must be ≥ 1.
- `FLOOR_W`, derived: `$clog2(FLOORS)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `car_btn`  in  FLOORS  car-panel buttons; level or pulse.
- `hall_up`  in  FLOORS  hall up-calls; bit FLOORS-1 is ignored.
- `hall_dn`  in  FLOORS  hall down-calls; bit 0 is ignored.
- `current_floor`  out  FLOOR_W  floor index of the car.
- `moving_up`  out  1  car travelling up.
- `moving_down`  out  1  car travelling down.
- `door_open`  out  1  door open.
- `dir_up`  out  1  current or last service direction.
- `pend_car`, `pend_up`, `pend_dn`  out  FLOORS each  latched pending requests.

## Operation
- **Request latching:** an asserted button sets its pending bit on the next edge. The bit stays set until serviced. Ignored bits (`hall_up[FLOORS-1]`, `hall_dn[0]`) never set.
- **Same-floor press:** a button at `current_floor` while the state is IDLE or DOOR is not latched. It restarts the door timer: from IDLE the door opens, and in DOOR the dwell is extended.
- **States:** IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- **"above" / "below":** any pending bit (car, up or down) at a floor greater or less than `current_floor`.
- **IDLE:**
  - Pending only above goes to MOVE_UP; pending only below goes to MOVE_DOWN.
  - Both above and below: keep `dir_up`.
  - None: stay in IDLE.
  - Entering a MOVE state sets `dir_up` to match the move.
- **MOVE_UP / MOVE_DOWN:**
  - The travel counter counts 0..TRAVEL_CYCLES-1. On the terminal count `current_floor` increments or decrements, the counter clears, and the stop decision uses the new floor.
  - Stop when the new floor has `pend_car`, the same-direction hall bit, or nothing pending further ahead.
  - Otherwise continue moving.
  - `current_floor` never passes 0 or FLOORS-1. Reaching an end floor always stops.
- **Stop entry (into DOOR):**
  - Clear `pend_car` and the same-direction hall bit at that floor.
  - If nothing is pending ahead, also clear the opposite hall bit and flip `dir_up`.
- **DOOR:**
  - `door_open` is high and the door counter runs DOOR_CYCLES.
  - At expiry:
    - pending ahead in `dir_up`: move that way;
    - else pending behind: flip `dir_up` and move;
    - else go to IDLE.
  - Moving out of DOOR starts the travel counter at 0.
- **Simultaneous events:** a press for a floor on the same edge the car stops there counts as serviced. The pending bit is not set.
- **Output decode:**
  - `moving_up` = state MOVE_UP; `moving_down` = state MOVE_DOWN; `door_open` = state DOOR.
  - These three are mutually exclusive.
- **Reset (async, any time, including mid-travel):**
  - State IDLE, `current_floor`=0, `dir_up`=1, counters 0, all pending 0.
  - All outputs are 0 except `dir_up`=1.

## Timing
- Button sampled at edge N: pending bit visible after edge N.
- From IDLE, the state leaves IDLE at edge N+1.
- `current_floor` changes exactly TRAVEL_CYCLES edges after MOVE is entered, or after the previous floor change.
- `door_open` is high for exactly DOOR_CYCLES cycles per stop, plus DOOR_CYCLES from each restart.
- Counter widths are `$clog2(max+1)`. Counters saturate at no point; they are always cleared on terminal count or state change.
- No combinational path from inputs to outputs; all outputs are registered or decoded from registered state.

## Structure
- **`lift_pkg`:**
  - state enum `lift_state_e` {IDLE, MOVE_UP, MOVE_DOWN, DOOR};
  - functions `any_above(mask, floor)` and `any_below(mask, floor)` over the OR of the pending vectors.
- **Sub-module `lift_req_reg`:**
  - holds one pending vector: set by button, clear by per-bit service mask, same-floor suppress;
  - instantiated three times (car, up, down).
- **`lift_ctrl`:** holds the FSM, the travel counter, the door counter and `dir_up`.

## Test plan
All scenarios use FLOORS=4, TRAVEL_CYCLES=3, DOOR_CYCLES=2.
1. **Reset:** assert `rst_n`=0 mid-cycle → `current_floor`=0, door and motion 0, pending 0, `dir_up`=1, without waiting for a clock edge.
2. **Single trip:** `car_btn`=0100 pulse at floor 0 → `moving_up` 1 cycle later; floor 1 after 3 cycles, floor 2 after 6; `door_open` for 2 cycles; `pend_car`=0000; then IDLE.
3. **Collective:**
   - Setup: car moving up 0→3 with `car_btn[3]` pending. Press `hall_up[1]` and `hall_dn[2]` before the car reaches floor 1.
   - Expected: stop at 1; pass 2; stop at 3; reverse; stop at 2 on the way down.
4. **Same floor:** `car_btn[0]` while IDLE at floor 0 → door opens with no motion. Re-press in the 2nd door cycle → door stays open 2 more cycles; `pend_car` stays 0000.
5. **Tie-break:**
   - Setup: at floor 2 with `dir_up`=0; `car_btn[3]` and `car_btn[0]` pressed on the same edge.
   - Expected: car goes down to 0 first, then up to 3.
6. **Reset mid-travel:** assert reset after the 2nd cycle toward floor 1 → floor 0, IDLE, all pending cleared. After release, no motion without new presses.
